// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, matmul sequencer states, byte-lane indices.
package alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRL    = 4'b0101;
  localparam logic [3:0] OP_ADD    = 4'b1000;
  localparam logic [3:0] OP_SUB    = 4'b1001;
  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_MATMUL = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL0,
    ST_MUL1,
    ST_ADD,
    ST_DONE
  } state_t;

  // Byte lane of element (row, col) in a packed 2x2 matrix is {row, col}.
  localparam logic [1:0] LANE_00 = 2'd0;
  localparam logic [1:0] LANE_01 = 2'd1;
  localparam logic [1:0] LANE_10 = 2'd2;
  localparam logic [1:0] LANE_11 = 2'd3;

  function automatic logic [7:0] lane(input logic [31:0] m, input logic [1:0] idx);
    return m[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/alu_matmul_opsel.sv
// Combinational ALU operand/opcode selector for the matmul sequencer.
// Drives all-zero operands and control whenever no ALU request is active.
module alu_matmul_opsel
  import alu_pkg::*;
#(
  parameter logic [3:0] ADD_CODE = 4'b1000,
  parameter logic [3:0] MUL_CODE = 4'b1010
) (
  input  state_t      state,
  input  logic [1:0]  k,
  input  logic        req,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  p0,
  input  logic [7:0]  p1,
  output logic [7:0]  src_a,
  output logic [7:0]  src_b,
  output logic [3:0]  ctrl
);

  // Element k = {i, j}: MUL0 uses a_i0*b_0j, MUL1 uses a_i1*b_1j.
  always_comb begin
    src_a = 8'd0;
    src_b = 8'd0;
    ctrl  = 4'b0000;
    if (req) begin
      case (state)
        ST_MUL0: begin
          src_a = lane(a, {k[1], 1'b0});
          src_b = lane(b, {1'b0, k[0]});
          ctrl  = MUL_CODE;
        end
        ST_MUL1: begin
          src_a = lane(a, {k[1], 1'b1});
          src_b = lane(b, {1'b1, k[0]});
          ctrl  = MUL_CODE;
        end
        ST_ADD: begin
          src_a = p0;
          src_b = p1;
          ctrl  = ADD_CODE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_matmul_seq.sv
// 2x2 8-bit matrix multiply sequencer time-sharing the pipeline ALU via req/gnt.
// Optional MATMUL_ZERO_SKIP_EN bypasses the ALU for micro-ops with a zero operand.
module alu_matmul_seq #(
  parameter logic [3:0] OP_ADD = 4'b1000,
  parameter logic [3:0] OP_MUL = 4'b1010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mat_a,
  input  logic [31:0] mat_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] mat_c,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [7:0]  alu_src_a,
  output logic [7:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  input  logic [7:0]  alu_result
);
  import alu_pkg::*;

  state_t      state, state_n;
  logic [1:0]  k, k_n;
  logic [31:0] a_r, b_r, a_n, b_n, mat_c_n;
  logic [7:0]  p0, p1, p0_n, p1_n, wr_val;
  logic        step_done, req_n;

`ifdef MATMUL_ZERO_SKIP_EN
  function automatic logic needs_alu(input state_t st, input logic [1:0] kk,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [7:0] q0, input logic [7:0] q1);
    case (st)
      ST_MUL0: return (lane(a, {kk[1], 1'b0}) != 8'd0) && (lane(b, {1'b0, kk[0]}) != 8'd0);
      ST_MUL1: return (lane(a, {kk[1], 1'b1}) != 8'd0) && (lane(b, {1'b1, kk[0]}) != 8'd0);
      ST_ADD:  return (q0 != 8'd0) && (q1 != 8'd0);
      default: return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_n = state;
    k_n     = k;
    a_n     = a_r;
    b_n     = b_r;
    p0_n    = p0;
    p1_n    = p1;
    mat_c_n = mat_c;
`ifdef MATMUL_ZERO_SKIP_EN
    // A skipped step completes immediately with the known result.
    step_done = alu_req ? alu_gnt : 1'b1;
    wr_val    = alu_req ? alu_result : ((state == ST_ADD) ? ((p0 == 8'd0) ? p1 : p0) : 8'd0);
`else
    step_done = alu_gnt;
    wr_val    = alu_result;
`endif
    case (state)
      ST_IDLE: if (start) begin
        a_n     = mat_a;
        b_n     = mat_b;
        k_n     = 2'd0;
        state_n = ST_MUL0;
      end
      ST_MUL0: if (step_done) begin
        p0_n    = wr_val;
        state_n = ST_MUL1;
      end
      ST_MUL1: if (step_done) begin
        p1_n    = wr_val;
        state_n = ST_ADD;
      end
      ST_ADD: if (step_done) begin
        mat_c_n[{k, 3'b000} +: 8] = wr_val;
        if (k == 2'd3) begin
          state_n = ST_DONE;
        end else begin
          k_n     = k + 2'd1;
          state_n = ST_MUL0;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
`ifdef MATMUL_ZERO_SKIP_EN
    req_n = needs_alu(state_n, k_n, a_n, b_n, p0_n, p1_n);
`else
    req_n = (state_n == ST_MUL0) || (state_n == ST_MUL1) || (state_n == ST_ADD);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      k       <= 2'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      p0      <= 8'd0;
      p1      <= 8'd0;
      mat_c   <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      a_r     <= a_n;
      b_r     <= b_n;
      p0      <= p0_n;
      p1      <= p1_n;
      mat_c   <= mat_c_n;
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
      alu_req <= req_n;
    end
  end

  alu_matmul_opsel #(
    .ADD_CODE(OP_ADD),
    .MUL_CODE(OP_MUL)
  ) u_opsel (
    .state(state),
    .k(k),
    .req(alu_req),
    .a(a_r),
    .b(b_r),
    .p0(p0),
    .p1(p1),
    .src_a(alu_src_a),
    .src_b(alu_src_b),
    .ctrl(alu_ctrl)
  );

endmodule
